aurora_link_sequencer: RTL and testbench
========================================

// Module: aurora_link_sequencer
// PURPOSE
//   Brings up and supervises the 2-lane Aurora link under the C2C master: sequences GT pma_init/reset_pb,
//   waits for PLL lock, lane/channel up and C2C link status, then releases the C2C aux reset.
//   Retries on timeout or link loss, latches FAULT after MAX_RETRIES. Drives the 4 board LEDs.
// PARAMETERS
//   NUM_LANES         2          Aurora lane count (width of lane_up)
//   PMA_INIT_CYCLES   256        cycles pma_init is held in PMA_RESET
//   RESET_PB_CYCLES   128        cycles reset_pb is held after pma_init release
//   TIMEOUT_CYCLES    1000000    max cycles in any WAIT_* state before retry
//   MAX_RETRIES       7          retries before FAULT (1..15)
//   HEARTBEAT_DIV     24         free-running counter width; MSB drives led_out[0]
// PORTS
//   aclk            in   1          system clock; all logic on rising edge
//   aresetn         in   1          synchronous active-low reset
//   enable          in   1          aclk-domain; 1 = bring link up, 0 = hold in reset
//   gt_pll_lock     in   1          async; GT PLL locked
//   lane_up         in   NUM_LANES  async; per-lane up
//   channel_up      in   1          async; Aurora channel up
//   c2c_link_status in   1          async; C2C bridge link established
//   c2c_link_error  in   1          async; C2C bridge link error
//   pma_init        out  1          GT PMA init (active-high)
//   reset_pb        out  1          Aurora reset pushbutton (active-high)
//   c2c_aux_reset   out  1          C2C aux_reset_in (active-high)
//   link_ready      out  1          1 only in LINKED
//   fault           out  1          1 only in FAULT
//   retry_count     out  4          retries used in current bring-up
//   state_out       out  3          current state encoding
//   led_out         out  4          {fault, link_ready, channel_up_s, heartbeat}
// BEHAVIOUR
//   - All async inputs pass through 2-flop synchronizers (+2 cycles latency); FSM uses synced copies only.
//   - Reset (aresetn=0 at edge): state IDLE, pma_init=1, reset_pb=1, c2c_aux_reset=1, link_ready=0,
//     fault=0, retry_count=0, led_out=0, timers/heartbeat=0.
//   - Outputs are registered and change on the same edge as state_out.
//   - States: IDLE=0, PMA_RESET=1, PB_RESET=2, WAIT_LOCK=3, WAIT_CHANNEL=4, WAIT_C2C=5, LINKED=6, FAULT=7.
//   - IDLE: all resets asserted; enable=1 -> PMA_RESET.
//   - PMA_RESET: pma_init=1, reset_pb=1 for exactly PMA_INIT_CYCLES cycles -> PB_RESET.
//   - PB_RESET: pma_init=0, reset_pb=1 for exactly RESET_PB_CYCLES cycles -> WAIT_LOCK.
//   - WAIT_LOCK: pma_init=0, reset_pb=0; gt_pll_lock_s=1 -> WAIT_CHANNEL.
//   - WAIT_CHANNEL: channel_up_s=1 and all lane_up_s=1 -> WAIT_C2C.
//   - WAIT_C2C: c2c_aux_reset=0; c2c_link_status_s=1 -> LINKED; retry_count cleared on entry to LINKED.
//   - c2c_aux_reset=1 in every state except WAIT_C2C and LINKED.
//   - LINKED: link_ready=1; any of channel_up_s=0, gt_pll_lock_s=0, c2c_link_error_s=1 -> RETRY.
//   - Timeout: per-state timer cleared on every transition; in WAIT_* after TIMEOUT_CYCLES cycles without
//     exit condition -> RETRY. Exit condition true on the final cycle wins over timeout.
//   - RETRY (action, not a state): retry_count==MAX_RETRIES -> FAULT; else retry_count+1, -> PMA_RESET.
//   - FAULT: all resets asserted, fault=1; sticky until enable=0 -> IDLE, retry_count cleared.
//   - enable=0 in any state -> IDLE next edge; highest priority over timeouts and link events.
//   - Heartbeat counter free-runs in all states incl. FAULT; wraps at 2^HEARTBEAT_DIV.
// TESTING  (PMA_INIT_CYCLES=8, RESET_PB_CYCLES=4, TIMEOUT_CYCLES=32, MAX_RETRIES=2, HEARTBEAT_DIV=4)
//   1. enable=1, inputs all 1 -> pma_init=1 exactly 8 cycles, reset_pb=1 12 cycles total, LINKED, link_ready=1.
//   2. gt_pll_lock held 0 -> 3 WAIT_LOCK timeouts of 32 cycles; state_out=7, fault=1, retry_count=2.
//   3. In LINKED drop channel_up -> link_ready=0 within 3 cycles, state_out=1, retry_count=1, pma_init=1.
//   4. enable=0 during WAIT_CHANNEL -> state_out=0 next edge, pma_init=reset_pb=c2c_aux_reset=1.
//   5. aresetn=0 one cycle while LINKED -> all outputs at reset values next edge, then bring-up restarts.
//   6. Synced lock arrives on timer cycle 32 of WAIT_LOCK -> WAIT_CHANNEL, retry_count stays 0.

Source files
------------

// File: rtl/aurora_link_sequencer.sv
// Aurora/C2C link bring-up sequencer: GT reset sequencing, lock/lane/channel/C2C waits,
// timeout-driven retries with a sticky fault, and board LED drive.
module aurora_link_sequencer #(
  parameter int NUM_LANES       = 2,
  parameter int PMA_INIT_CYCLES = 256,
  parameter int RESET_PB_CYCLES = 128,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int MAX_RETRIES     = 7,
  parameter int HEARTBEAT_DIV   = 24
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 gt_pll_lock,
  input  logic [NUM_LANES-1:0] lane_up,
  input  logic                 channel_up,
  input  logic                 c2c_link_status,
  input  logic                 c2c_link_error,
  output logic                 pma_init,
  output logic                 reset_pb,
  output logic                 c2c_aux_reset,
  output logic                 link_ready,
  output logic                 fault,
  output logic [3:0]           retry_count,
  output logic [2:0]           state_out,
  output logic [3:0]           led_out
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PMA_RESET    = 3'd1,
    PB_RESET     = 3'd2,
    WAIT_LOCK    = 3'd3,
    WAIT_CHANNEL = 3'd4,
    WAIT_C2C     = 3'd5,
    LINKED       = 3'd6,
    FAULT        = 3'd7
  } state_t;

  localparam int SYNC_W = NUM_LANES + 4;
  localparam int T_MAX0 = (PMA_INIT_CYCLES > RESET_PB_CYCLES) ? PMA_INIT_CYCLES : RESET_PB_CYCLES;
  localparam int T_MAX  = (T_MAX0 > TIMEOUT_CYCLES) ? T_MAX0 : TIMEOUT_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);

  logic [SYNC_W-1:0]        sync1, sync2;
  logic                     lock_s, channel_up_s, link_status_s, link_error_s;
  logic [NUM_LANES-1:0]     lane_up_s;
  logic [TW-1:0]            timer;
  logic [HEARTBEAT_DIV-1:0] heartbeat;
  state_t                   state, state_nxt;
  logic [3:0]               retry_nxt;
  logic                     retry_req, timed_out;

  // Two-flop synchronizers for every asynchronous status input.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {c2c_link_error, c2c_link_status, channel_up, lane_up, gt_pll_lock};
      sync2 <= sync1;
    end
  end

  assign {link_error_s, link_status_s, channel_up_s, lane_up_s, lock_s} = sync2;
  assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    retry_req = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      retry_nxt = '0;
    end else begin
      case (state)
        IDLE:         state_nxt = PMA_RESET;
        PMA_RESET:    if (timer == TW'(PMA_INIT_CYCLES - 1)) state_nxt = PB_RESET;
        PB_RESET:     if (timer == TW'(RESET_PB_CYCLES - 1)) state_nxt = WAIT_LOCK;
        WAIT_LOCK:    if (lock_s) state_nxt = WAIT_CHANNEL;
                      else if (timed_out) retry_req = 1'b1;
        WAIT_CHANNEL: if (channel_up_s && (&lane_up_s)) state_nxt = WAIT_C2C;
                      else if (timed_out) retry_req = 1'b1;
        WAIT_C2C:     if (link_status_s) state_nxt = LINKED;
                      else if (timed_out) retry_req = 1'b1;
        LINKED:       if (!channel_up_s || !lock_s || link_error_s) retry_req = 1'b1;
        FAULT:        state_nxt = FAULT;
        default:      state_nxt = IDLE;
      endcase
      if (retry_req) begin
        if (retry_count == 4'(MAX_RETRIES)) begin
          state_nxt = FAULT;
        end else begin
          retry_nxt = retry_count + 4'd1;
          state_nxt = PMA_RESET;
        end
      end
      if (state_nxt == LINKED && state != LINKED) retry_nxt = '0;
    end
  end

  // NOTE: outputs are decoded from state_nxt and registered, so they switch on the same edge as state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      retry_count   <= '0;
      timer         <= '0;
      pma_init      <= 1'b1;
      reset_pb      <= 1'b1;
      c2c_aux_reset <= 1'b1;
      link_ready    <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      retry_count   <= retry_nxt;
      if (state_nxt != state || !(state inside {PMA_RESET, PB_RESET, WAIT_LOCK, WAIT_CHANNEL, WAIT_C2C}))
        timer <= '0;
      else
        timer <= timer + TW'(1);
      pma_init      <= (state_nxt inside {IDLE, PMA_RESET, FAULT});
      reset_pb      <= (state_nxt inside {IDLE, PMA_RESET, PB_RESET, FAULT});
      c2c_aux_reset <= !(state_nxt inside {WAIT_C2C, LINKED});
      link_ready    <= (state_nxt == LINKED);
      fault         <= (state_nxt == FAULT);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) heartbeat <= '0;
    else          heartbeat <= heartbeat + HEARTBEAT_DIV'(1);
  end

  assign state_out = state;
  assign led_out   = {fault, link_ready, channel_up_s, heartbeat[HEARTBEAT_DIV-1]};

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Bench for aurora_link_sequencer: vector table, directed corner sequences and randomized
// input traffic, all compared every cycle against a phase/age reference model.
module tb_aurora_link_sequencer;

  localparam int PMA  = 8;
  localparam int PB   = 4;
  localparam int TO   = 32;
  localparam int MAXR = 2;

  logic       aclk, aresetn, enable, gt_pll_lock, channel_up, c2c_link_status, c2c_link_error;
  logic [1:0] lane_up;
  logic       pma_init, reset_pb, c2c_aux_reset, link_ready, fault;
  logic [3:0] retry_count, led_out;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_err    = 0;

  aurora_link_sequencer #(
    .NUM_LANES(2), .PMA_INIT_CYCLES(PMA), .RESET_PB_CYCLES(PB),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR), .HEARTBEAT_DIV(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .gt_pll_lock(gt_pll_lock),
    .lane_up(lane_up), .channel_up(channel_up), .c2c_link_status(c2c_link_status),
    .c2c_link_error(c2c_link_error), .pma_init(pma_init), .reset_pb(reset_pb),
    .c2c_aux_reset(c2c_aux_reset), .link_ready(link_ready), .fault(fault),
    .retry_count(retry_count), .state_out(state_out), .led_out(led_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: phase number, cycles spent in phase, retries, beat count and
  // a history of raw inputs from which the 2-cycle-late synced view is read.
  int         m_phase, m_age, m_retry, m_beats;
  logic       m_cu_s;
  logic [5:0] hist[$];

  task automatic model_edge();
    logic [5:0] seen, cur;
    int         nxt;
    bit         fail;
    cur = {c2c_link_error, c2c_link_status, channel_up, lane_up, gt_pll_lock};
    if (!aresetn) begin
      m_phase = 0; m_age = 0; m_retry = 0; m_beats = 0; m_cu_s = 1'b0;
      hist.delete();
      return;
    end
    m_beats = (m_beats + 1) % 16;
    seen = (hist.size() >= 2) ? hist[hist.size()-2] : 6'd0;
    hist.push_back(cur);
    if (hist.size() > 3) void'(hist.pop_front());
    m_cu_s = (hist.size() >= 2) ? hist[hist.size()-2][3] : 1'b0;
    if (!enable) begin
      m_phase = 0; m_retry = 0; m_age = 0;
      return;
    end
    nxt  = m_phase;
    fail = 1'b0;
    case (m_phase)
      0: nxt = 1;
      1: if (m_age + 1 >= PMA) nxt = 2;
      2: if (m_age + 1 >= PB) nxt = 3;
      3: if (seen[0]) nxt = 4; else if (m_age + 1 >= TO) fail = 1'b1;
      4: if (seen[3] && seen[2] && seen[1]) nxt = 5; else if (m_age + 1 >= TO) fail = 1'b1;
      5: if (seen[4]) nxt = 6; else if (m_age + 1 >= TO) fail = 1'b1;
      6: if (!seen[3] || !seen[0] || seen[5]) fail = 1'b1;
      default: ;
    endcase
    if (fail) begin
      if (m_retry == MAXR) nxt = 7;
      else begin m_retry++; nxt = 1; end
    end
    if (nxt == 6 && m_phase != 6) m_retry = 0;
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
  endtask

  function automatic logic [15:0] model_out();
    logic pma, pb, aux, rdy, flt;
    pma = (m_phase == 0 || m_phase == 1 || m_phase == 7);
    pb  = (m_phase <= 2 || m_phase == 7);
    aux = !(m_phase == 5 || m_phase == 6);
    rdy = (m_phase == 6);
    flt = (m_phase == 7);
    return {3'(m_phase), 4'(m_retry), pma, pb, aux, rdy, flt, flt, rdy, m_cu_s, logic'(m_beats >= 8)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
    check("cycle", {16'd0, state_out, retry_count, pma_init, reset_pb, c2c_aux_reset,
                    link_ready, fault, led_out}, {16'd0, model_out()});
  endtask

  task automatic set_in(input logic lock, input logic [1:0] lanes, input logic cu,
                        input logic st, input logic err);
    gt_pll_lock = lock; lane_up = lanes; channel_up = cu;
    c2c_link_status = st; c2c_link_error = err;
  endtask

  typedef struct {
    logic       rstn, en, lock;
    logic [1:0] lanes;
    logic       cu, st, err;
    int         n;
    logic [2:0] st_exp;
    logic [3:0] retry_exp;
    logic [4:0] flags_exp;  // {pma_init, reset_pb, c2c_aux_reset, link_ready, fault}
  } vec_t;

  vec_t vecs[10];

  initial begin
    int pma_n, pb_n, len, eps, k;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2, 3'd0, 4'd0, 5'b11100};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1, 3'd1, 4'd0, 5'b11100};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8, 3'd2, 4'd0, 5'b01100};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 4, 3'd3, 4'd0, 5'b00100};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1, 3'd4, 4'd0, 5'b00100};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1, 3'd5, 4'd0, 5'b00000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1, 3'd6, 4'd0, 5'b00010};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 2, 3'd6, 4'd0, 5'b00010};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1, 3'd1, 4'd1, 5'b11100};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1, 3'd0, 4'd0, 5'b11100};

    aresetn = 1'b0; enable = 1'b0;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset, bring-up, link drop and disable via the vector table.
    for (int i = 0; i < 10; i++) begin
      aresetn = vecs[i].rstn; enable = vecs[i].en;
      set_in(vecs[i].lock, vecs[i].lanes, vecs[i].cu, vecs[i].st, vecs[i].err);
      repeat (vecs[i].n) step();
      check($sformatf("vec%0d", i),
            {20'd0, state_out, retry_count, pma_init, reset_pb, c2c_aux_reset, link_ready, fault},
            {20'd0, vecs[i].st_exp, vecs[i].retry_exp, vecs[i].flags_exp});
    end

    // Full bring-up: measure reset pulse widths.
    pma_n = 0; pb_n = 0;
    enable = 1'b1;
    for (int c = 0; c < 100 && !link_ready; c++) begin
      step();
      if (pma_init) pma_n++;
      if (reset_pb) pb_n++;
    end
    check("t1_pma_cycles", pma_n, PMA);
    check("t1_pb_cycles", pb_n, PMA + PB);
    check("t1_linked", link_ready, 1'b1);

    // One-cycle reset while linked.
    aresetn = 1'b0;
    step();
    check("t5_reset_vals", {state_out, retry_count, pma_init, reset_pb, c2c_aux_reset,
                            link_ready, fault, led_out}, {3'd0, 4'd0, 5'b11100, 4'd0});
    aresetn = 1'b1;
    step();
    check("t5_restart", state_out, 3'd1);

    // PLL never locks: three WAIT_LOCK timeouts then FAULT.
    enable = 1'b0; step();
    gt_pll_lock = 1'b0; enable = 1'b1;
    len = 0; eps = 0;
    for (int c = 0; c < 400 && state_out != 3'd7; c++) begin
      step();
      if (state_out == 3'd3) len++;
      else if (len > 0) begin
        check("t2_wait_len", len, TO);
        eps++;
        len = 0;
      end
    end
    check("t2_episodes", eps, 3);
    check("t2_fault", {state_out, fault, retry_count}, {3'd7, 1'b1, 4'd2});
    gt_pll_lock = 1'b1;
    repeat (20) step();
    check("t2_sticky", state_out, 3'd7);
    enable = 1'b0; step();
    check("t2_clear", {state_out, retry_count}, {3'd0, 4'd0});

    // Disable during WAIT_CHANNEL.
    set_in(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 50 && state_out != 3'd4; c++) step();
    check("t4_reach", state_out, 3'd4);
    repeat (5) step();
    enable = 1'b0; step();
    check("t4_idle", {state_out, pma_init, reset_pb, c2c_aux_reset}, {3'd0, 3'b111});

    // Lock arriving on the final timer cycle wins; one cycle later retries.
    for (int late = 0; late < 2; late++) begin
      enable = 1'b0; step();
      set_in(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
      enable = 1'b1;
      for (int c = 0; c < 50 && state_out != 3'd3; c++) step();
      check("t6_reach", state_out, 3'd3);
      k = 29 + late;
      repeat (k) step();
      gt_pll_lock = 1'b1;
      repeat (2 - late) step();
      check("t6_hold", state_out, 3'd3);
      step();
      if (late == 0) check("t6_edge_win", {state_out, retry_count}, {3'd4, 4'd0});
      else           check("t6_edge_late", {state_out, retry_count}, {3'd1, 4'd1});
    end

    // Randomized traffic against the model.
    enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      aresetn = ($urandom_range(0, 499) != 0);
      enable  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) gt_pll_lock = ~gt_pll_lock;
      if ($urandom_range(0, 39) == 0) lane_up[0] = ~lane_up[0];
      if ($urandom_range(0, 39) == 0) lane_up[1] = ~lane_up[1];
      if ($urandom_range(0, 29) == 0) channel_up = ~channel_up;
      if ($urandom_range(0, 29) == 0) c2c_link_status = ~c2c_link_status;
      c2c_link_error = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
